// File: rtl/pair_issue_split_pkg.sv
// rtl/pair_issue_split_pkg.sv - shared widths and FSM state encoding for the pair issue splitter
package pair_issue_split_pkg;

  localparam int AWIDTH       = 32;
  localparam int OPCODE_WIDTH = 6;
  localparam int DEF_IWIDTH   = 32;
  localparam int DEF_PCWIDTH  = 32;

  typedef enum logic {
    PS_PASS  = 1'b0,
    PS_HOLD2 = 1'b1
  } ps_state_e;

endpackage

// File: rtl/pair_issue_split_issue_slot_reg.sv
// rtl/pair_issue_split_issue_slot_reg.sv - valid/instr/pc register with load and clear
module issue_slot_reg #(
  parameter int IW = 32,
  parameter int PW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          ld_i,
  input  logic          valid_i,
  input  logic [IW-1:0] instr_i,
  input  logic [PW-1:0] pc_i,
  output logic          valid_o,
  output logic [IW-1:0] instr_o,
  output logic [PW-1:0] pc_o
);

  logic          valid_q;
  logic [IW-1:0] instr_q;
  logic [PW-1:0] pc_q;

  // Clear only drops the valid; payload is don't-care once invalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (ld_i) begin
      valid_q <= valid_i;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/pair_issue_split.sv
// rtl/pair_issue_split.sv - dual-issue serializer splitting dependent pairs; PS_SPLIT_CNT_EN adds a split counter
module pair_issue_split
  import pair_issue_split_pkg::*;
#(
  parameter int IWIDTH  = DEF_IWIDTH,
  parameter int PCWIDTH = DEF_PCWIDTH
) (
  input  logic               ps_i_clk,
  input  logic               ps_i_rst,
  input  logic               ps_i_flush,
  input  logic               ps_i_valid,
  output logic               ps_o_ready,
  input  logic [IWIDTH-1:0]  ps_i_instr_1,
  input  logic [IWIDTH-1:0]  ps_i_instr_2,
  input  logic [PCWIDTH-1:0] ps_i_pc_1,
  input  logic [PCWIDTH-1:0] ps_i_pc_2,
  input  logic               ps_i_dup,
  input  logic               ps_i_ready,
  output logic               ps_o_valid_1,
  output logic               ps_o_valid_2,
  output logic [IWIDTH-1:0]  ps_o_instr_1,
  output logic [IWIDTH-1:0]  ps_o_instr_2,
  output logic [PCWIDTH-1:0] ps_o_pc_1,
  output logic [PCWIDTH-1:0] ps_o_pc_2
`ifdef PS_SPLIT_CNT_EN
  ,
  output logic [31:0]        ps_o_split_cnt
`endif
);

  ps_state_e state_q, state_d;

  logic               load_en;
  logic               accept;
  logic               hold_valid;
  logic [IWIDTH-1:0]  hold_instr;
  logic [PCWIDTH-1:0] hold_pc;

  logic               s1_ld, s1_valid_d;
  logic [IWIDTH-1:0]  s1_instr_d;
  logic [PCWIDTH-1:0] s1_pc_d;
  logic               s2_valid_d;
  logic               hold_ld, hold_clr;

  assign load_en    = !ps_o_valid_1 || ps_i_ready;
  assign ps_o_ready = !ps_i_flush && (state_q == PS_PASS) && load_en;
  assign accept     = ps_i_valid && ps_o_ready;

  always_comb begin
    state_d    = state_q;
    s1_ld      = !ps_i_flush && load_en;
    s1_valid_d = accept;
    s1_instr_d = ps_i_instr_1;
    s1_pc_d    = ps_i_pc_1;
    s2_valid_d = accept && !ps_i_dup;
    hold_ld    = 1'b0;
    hold_clr   = ps_i_flush;
    if (ps_i_flush) begin
      state_d = PS_PASS;
    end else begin
      case (state_q)
        PS_PASS: begin
          if (accept && ps_i_dup) begin
            hold_ld = 1'b1;
            state_d = PS_HOLD2;
          end
        end
        PS_HOLD2: begin
          // The held younger instruction always goes out alone in slot 1.
          s1_valid_d = hold_valid;
          s1_instr_d = hold_instr;
          s1_pc_d    = hold_pc;
          s2_valid_d = 1'b0;
          if (load_en) begin
            hold_clr = 1'b1;
            state_d  = PS_PASS;
          end
        end
        default: state_d = PS_PASS;
      endcase
    end
  end

  always_ff @(posedge ps_i_clk or negedge ps_i_rst) begin
    if (!ps_i_rst) state_q <= PS_PASS;
    else           state_q <= state_d;
  end

  issue_slot_reg #(.IW(IWIDTH), .PW(PCWIDTH)) u_slot1 (
    .clk_i(ps_i_clk), .rst_ni(ps_i_rst), .clr_i(ps_i_flush), .ld_i(s1_ld),
    .valid_i(s1_valid_d), .instr_i(s1_instr_d), .pc_i(s1_pc_d),
    .valid_o(ps_o_valid_1), .instr_o(ps_o_instr_1), .pc_o(ps_o_pc_1)
  );

  issue_slot_reg #(.IW(IWIDTH), .PW(PCWIDTH)) u_slot2 (
    .clk_i(ps_i_clk), .rst_ni(ps_i_rst), .clr_i(ps_i_flush), .ld_i(s1_ld),
    .valid_i(s2_valid_d), .instr_i(ps_i_instr_2), .pc_i(ps_i_pc_2),
    .valid_o(ps_o_valid_2), .instr_o(ps_o_instr_2), .pc_o(ps_o_pc_2)
  );

  issue_slot_reg #(.IW(IWIDTH), .PW(PCWIDTH)) u_hold (
    .clk_i(ps_i_clk), .rst_ni(ps_i_rst), .clr_i(hold_clr), .ld_i(hold_ld),
    .valid_i(1'b1), .instr_i(ps_i_instr_2), .pc_i(ps_i_pc_2),
    .valid_o(hold_valid), .instr_o(hold_instr), .pc_o(hold_pc)
  );

`ifdef PS_SPLIT_CNT_EN
  logic [31:0] split_cnt_q, split_cnt_d;

  assign split_cnt_d = split_cnt_q + 32'd1;

  always_ff @(posedge ps_i_clk or negedge ps_i_rst) begin
    if (!ps_i_rst)               split_cnt_q <= '0;
    else if (accept && ps_i_dup) split_cnt_q <= split_cnt_d;
  end

  assign ps_o_split_cnt = split_cnt_q;
`endif

endmodule

// File: tb/tb_pair_issue_split.sv
// tb/tb_pair_issue_split.sv - directed self-checking bench for pair_issue_split
module tb_pair_issue_split;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] instr_1, instr_2, pc_1, pc_2;
  logic        dup;
  logic        ready_in;
  logic        valid_1, valid_2;
  logic [31:0] o_instr_1, o_instr_2, o_pc_1, o_pc_2;
`ifdef PS_SPLIT_CNT_EN
  logic [31:0] split_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pair_issue_split dut (
    .ps_i_clk(clk), .ps_i_rst(rst_n), .ps_i_flush(flush),
    .ps_i_valid(valid_in), .ps_o_ready(ready_out),
    .ps_i_instr_1(instr_1), .ps_i_instr_2(instr_2),
    .ps_i_pc_1(pc_1), .ps_i_pc_2(pc_2), .ps_i_dup(dup),
    .ps_i_ready(ready_in),
    .ps_o_valid_1(valid_1), .ps_o_valid_2(valid_2),
    .ps_o_instr_1(o_instr_1), .ps_o_instr_2(o_instr_2),
    .ps_o_pc_1(o_pc_1), .ps_o_pc_2(o_pc_2)
`ifdef PS_SPLIT_CNT_EN
    , .ps_o_split_cnt(split_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] p1, input logic [31:0] p2, input logic d);
    valid_in = v;
    pc_1     = p1;
    pc_2     = p2;
    instr_1  = p1 ^ 32'hA5A5_0000;
    instr_2  = p2 ^ 32'hA5A5_0000;
    dup      = d;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; ready_in = 1'b1;
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    if (valid_1 !== 1'b0) begin errors++; $display("FAIL reset_v1 got %b exp 0", valid_1); end
    checks++;
    if (valid_2 !== 1'b0) begin errors++; $display("FAIL reset_v2 got %b exp 0", valid_2); end
    checks++;
    if (o_pc_1 !== 32'h0 || o_instr_1 !== 32'h0) begin errors++; $display("FAIL reset_slot1 got %h/%h exp 0/0", o_pc_1, o_instr_1); end
    checks++;
    rst_n = 1'b1;
    tick();
    if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_out); end
    checks++;
  endtask

  task automatic test_independent();
    offer(1'b1, 32'h100, 32'h104, 1'b0);
    tick();
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    if (valid_1 !== 1'b1 || valid_2 !== 1'b1) begin errors++; $display("FAIL indep_valids got %b%b exp 11", valid_1, valid_2); end
    checks++;
    if (o_pc_1 !== 32'h100 || o_pc_2 !== 32'h104) begin errors++; $display("FAIL indep_pcs got %h/%h exp 100/104", o_pc_1, o_pc_2); end
    checks++;
    if (o_instr_2 !== 32'hA5A5_0104) begin errors++; $display("FAIL indep_instr2 got %h exp a5a50104", o_instr_2); end
    checks++;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL indep_ready got %b exp 1", ready_out); end
    checks++;
    tick();
    if (valid_1 !== 1'b0) begin errors++; $display("FAIL indep_drain got %b exp 0", valid_1); end
    checks++;
  endtask

  task automatic test_dup();
    offer(1'b1, 32'h200, 32'h204, 1'b1);
    tick();
    offer(1'b1, 32'h300, 32'h304, 1'b0);
    if (valid_1 !== 1'b1 || o_pc_1 !== 32'h200 || valid_2 !== 1'b0) begin errors++; $display("FAIL dup_c1 got %b/%h/%b exp 1/200/0", valid_1, o_pc_1, valid_2); end
    checks++;
    if (ready_out !== 1'b0) begin errors++; $display("FAIL dup_c1_ready got %b exp 0", ready_out); end
    checks++;
    tick();
    if (valid_1 !== 1'b1 || o_pc_1 !== 32'h204 || valid_2 !== 1'b0) begin errors++; $display("FAIL dup_c2 got %b/%h/%b exp 1/204/0", valid_1, o_pc_1, valid_2); end
    checks++;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL dup_c2_ready got %b exp 1", ready_out); end
    checks++;
    tick();
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    if (o_pc_1 !== 32'h300 || o_pc_2 !== 32'h304 || valid_2 !== 1'b1) begin errors++; $display("FAIL dup_next_pair got %h/%h/%b exp 300/304/1", o_pc_1, o_pc_2, valid_2); end
    checks++;
    tick();
  endtask

  task automatic test_stall();
    offer(1'b1, 32'h200, 32'h204, 1'b1);
    tick();
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (o_pc_1 !== 32'h200 || valid_1 !== 1'b1 || ready_out !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got %h/%b/%b exp 200/1/0", i, o_pc_1, valid_1, ready_out); end
      checks++;
      tick();
    end
    ready_in = 1'b1;
    #1;
    if (o_pc_1 !== 32'h200) begin errors++; $display("FAIL stall_still got %h exp 200", o_pc_1); end
    checks++;
    tick();
    if (o_pc_1 !== 32'h204 || valid_1 !== 1'b1 || valid_2 !== 1'b0) begin errors++; $display("FAIL stall_release got %h/%b/%b exp 204/1/0", o_pc_1, valid_1, valid_2); end
    checks++;
    tick();
    if (valid_1 !== 1'b0) begin errors++; $display("FAIL stall_nodup got %b exp 0", valid_1); end
    checks++;
  endtask

  task automatic test_flush_hold();
    offer(1'b1, 32'h200, 32'h204, 1'b1);
    tick();
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    flush = 1'b1;
    #1;
    if (ready_out !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", ready_out); end
    checks++;
    tick();
    flush = 1'b0;
    #1;
    if (valid_1 !== 1'b0 || valid_2 !== 1'b0 || ready_out !== 1'b1) begin errors++; $display("FAIL flush_after got %b%b/%b exp 00/1", valid_1, valid_2, ready_out); end
    checks++;
    offer(1'b1, 32'h400, 32'h404, 1'b0);
    tick();
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    if (o_pc_1 !== 32'h400 || valid_2 !== 1'b1) begin errors++; $display("FAIL flush_newpair got %h/%b exp 400/1", o_pc_1, valid_2); end
    checks++;
    tick();
    if (valid_1 !== 1'b0) begin errors++; $display("FAIL flush_noheld got %b exp 0", valid_1); end
    checks++;
  endtask

  task automatic test_flush_dup_same();
    offer(1'b1, 32'h500, 32'h504, 1'b1);
    flush = 1'b1;
    #1;
    if (ready_out !== 1'b0) begin errors++; $display("FAIL fdup_ready got %b exp 0", ready_out); end
    checks++;
    tick();
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    if (valid_1 !== 1'b0 || ready_out !== 1'b1) begin errors++; $display("FAIL fdup_after got %b/%b exp 0/1", valid_1, ready_out); end
    checks++;
    tick();
    if (valid_1 !== 1'b0) begin errors++; $display("FAIL fdup_nohold got %b exp 0", valid_1); end
    checks++;
  endtask

  task automatic test_async_reset();
    offer(1'b1, 32'h600, 32'h604, 1'b1);
    tick();
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    ready_in = 1'b0;
    if (o_pc_1 !== 32'h600) begin errors++; $display("FAIL arst_pre got %h exp 600", o_pc_1); end
    checks++;
    #1 rst_n = 1'b0;
    #1;
    if (valid_1 !== 1'b0 || o_pc_1 !== 32'h0 || o_instr_1 !== 32'h0 || valid_2 !== 1'b0) begin errors++; $display("FAIL arst_now got %b/%h/%h/%b exp 0/0/0/0", valid_1, o_pc_1, o_instr_1, valid_2); end
    checks++;
`ifdef PS_SPLIT_CNT_EN
    if (split_cnt !== 32'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", split_cnt); end
    checks++;
`endif
    #3 rst_n = 1'b1;
    ready_in = 1'b1;
    tick();
    if (ready_out !== 1'b1) begin errors++; $display("FAIL arst_ready got %b exp 1", ready_out); end
    checks++;
    tick();
    if (valid_1 !== 1'b0) begin errors++; $display("FAIL arst_discard got %b exp 0", valid_1); end
    checks++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 32'h700 + 32'(i * 8), 32'h704 + 32'(i * 8), 1'b0);
      tick();
      if (o_pc_1 !== 32'h700 + 32'(i * 8) || valid_2 !== 1'b1) begin errors++; $display("FAIL b2b_%0d got %h/%b exp %h/1", i, o_pc_1, valid_2, 32'h700 + 32'(i * 8)); end
      checks++;
    end
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
  endtask

`ifdef PS_SPLIT_CNT_EN
  task automatic test_split_cnt();
    logic [4:0] pattern;
    int         waited;
    pattern = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      offer(1'b1, 32'h800 + 32'(i * 8), 32'h804 + 32'(i * 8), pattern[i]);
      waited = 0;
      while (ready_out !== 1'b1 && waited < 4) begin
        tick();
        #1;
        waited++;
      end
      if (waited >= 4) begin errors++; $display("FAIL cnt_timeout got ready %b exp 1", ready_out); end
      tick();
    end
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) tick();
    offer(1'b1, 32'h900, 32'h904, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    if (split_cnt !== 32'd3) begin errors++; $display("FAIL split_cnt got %0d exp 3", split_cnt); end
    checks++;
  endtask
`endif

  initial begin
    test_reset();
    test_independent();
    test_dup();
    test_stall();
    test_flush_hold();
    test_flush_dup_same();
    test_async_reset();
    test_back_to_back();
`ifdef PS_SPLIT_CNT_EN
    test_split_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pair_issue_split.md
# pair_issue_split

Dual-issue serializer between the fetch-pair register and the two issue slots. It accepts an instruction pair each cycle and forwards it to issue as a pair when independent. When the intra-pair dependency flag is asserted, it issues instruction 1 alone and issues the held instruction 2 on the next accepted issue cycle. The output is a registered one-stage buffer with valid/ready handshakes on both sides, so issue-side stalls back-pressure fetch.

## Interface
- IWIDTH, 32, instruction word width
- PCWIDTH, 32, PC width
- ps_i_clk  in  1  clock, rising edge
- ps_i_rst  in  1  asynchronous active-low reset
- ps_i_flush  in  1  synchronous flush (branch/JR redirect), highest priority after reset
- ps_i_valid  in  1  fetch pair valid
- ps_o_ready  out  1  pair accepted this cycle when ps_i_valid && ps_o_ready
- ps_i_instr_1, ps_i_instr_2  in  IWIDTH  older / younger instruction of the pair
- ps_i_pc_1, ps_i_pc_2  in  PCWIDTH  matching PCs
- ps_i_dup  in  1  pair must be split: instr 2 reads instr 1's rd, or instr 2 is JR
- ps_i_ready  in  1  issue stage consumes the output this cycle
- ps_o_valid_1, ps_o_valid_2  out  1  slot valids
- ps_o_instr_1, ps_o_instr_2  out  IWIDTH  slot instructions
- ps_o_pc_1, ps_o_pc_2  out  PCWIDTH  slot PCs
- ps_o_split_cnt  out  32  number of split pairs (present only with PS_SPLIT_CNT_EN)

## Operation
- load_en = !ps_o_valid_1 || ps_i_ready. The output register is empty or is being consumed.
- Two states: PASS and HOLD2.
- PASS: ps_o_ready = load_en.
  - On accept with ps_i_dup=0: slot1 <- pair 1, slot2 <- pair 2, both valid.
  - On accept with ps_i_dup=1: slot1 <- pair 1, valid_2 <- 0, hold register <- pair 2, next state HOLD2.
  - load_en without accept: both valids <- 0.
- HOLD2: ps_o_ready = 0.
  - On load_en: slot1 <- hold register, valid_2 <- 0, next state PASS.
  - Otherwise: hold.
- A held instruction always issues in slot 1. The oldest instruction is always in slot 1.
- Invariant: ps_o_valid_2 implies ps_o_valid_1.
- ps_i_dup is ignored unless ps_i_valid && ps_o_ready.
- Output data are held stable while ps_o_valid_1 && !ps_i_ready.
- Flush: clears both valids and the hold register valid, sets state to PASS, and drops any pair offered the same cycle. ps_o_ready is forced to 0 during flush.
- Reset (async, ps_i_rst=0): state PASS, all valids 0, all instr/pc outputs 0, counter 0. Immediately after reset release, ps_o_ready=1.

## Timing
- Latency is 1 cycle from accept to output valid.
- Throughput:
  - 2 instr/cycle for independent pairs.
  - A split pair occupies 2 issue cycles and blocks fetch for exactly 1 cycle when ps_i_ready stays high.
- ps_o_ready is combinational from ps_i_ready, state, and ps_i_flush. There is no other comb path from input to output.
- Issue stall in HOLD2: the state persists, and the held instruction issues on the first cycle with ps_i_ready=1.
- Flush in the same cycle as a dup accept: the flush wins, nothing is captured, and the state stays PASS.
- Reset mid-HOLD2: the held instruction is discarded.

## Configuration
- PS_SPLIT_CNT_EN defined:
  - ps_o_split_cnt increments by 1 on every accepted pair with ps_i_dup=1 and flush=0.
  - It wraps 0xFFFFFFFF -> 0 and is cleared only by reset.
- PS_SPLIT_CNT_EN undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- header.vh gains:
  - PS_PASS=1'b0 and PS_HOLD2=1'b1 state encodings.
  - IWIDTH/PCWIDTH defaults alongside the existing AWIDTH/OPCODE_WIDTH.
- One sub-module, issue_slot_reg:
  - valid+instr+pc register with load and clear, async active-low reset.
  - Instantiated for slot1, slot2, and the hold register.
- The FSM and handshake logic stay in the top module.

## Test plan
- Independent pair, ps_i_dup=0, ps_i_ready=1, pcs 0x100/0x104: next cycle valid_1=valid_2=1 with both pcs, ps_o_ready stays 1.
- Dependent pair, ps_i_dup=1, pcs 0x200/0x204: cycle+1 slot1 pc 0x200 with valid_2=0 and ps_o_ready=0; cycle+2 slot1 pc 0x204, state PASS, ps_o_ready=1.
- Dup pair with ps_i_ready=0 for 3 cycles after capture: slot1 holds 0x200 for 3 cycles, then 0x204 issues in the cycle after ps_i_ready rises, with no loss or duplication.
- Flush asserted in HOLD2: next cycle both valids are 0, state PASS, held 0x204 never appears, and a new pair is accepted the following cycle.
- Async reset pulled low mid-transfer: outputs are zero at once without a clock edge, and ps_o_ready=1 after release.
- PS_SPLIT_CNT_EN defined, 5 pairs with dup pattern 1,0,1,1,0: ps_o_split_cnt=3. A flush cycle coincident with a dup offer does not increment it.
